// File: rtl/traffic_pkg.sv
// Shared light encodings, FSM state codes, fault-code bit indices and code-check helpers
// for the traffic lamp safety driver.
package traffic_pkg;

    localparam int unsigned LT_W = 3;

    typedef logic [LT_W-1:0] light_t;

    localparam light_t LT_RED = 3'b100;
    localparam light_t LT_YEL = 3'b010;
    localparam light_t LT_GRN = 3'b001;
    localparam light_t LT_OFF = 3'b000;

    typedef struct packed {
        light_t m1;
        light_t m2;
        light_t mt;
        light_t s;
    } lamp_set_t;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FAULT   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam int unsigned FC_INVALID  = 0;
    localparam int unsigned FC_CONFLICT = 1;
    localparam int unsigned FC_STALL    = 2;

    function automatic logic is_onehot(input light_t c);
        return (c == LT_RED) || (c == LT_YEL) || (c == LT_GRN);
    endfunction

    // Yellow or green bit lit means the approach is released.
    function automatic logic is_active(input light_t c);
        return c[1] | c[0];
    endfunction

endpackage

// File: rtl/traffic_lamp_safety_driver_if.sv
// Controller-to-lamp-driver bundle: light codes and fault clear in, lamp drive and fault status out.
interface traffic_lamp_safety_driver_if;

    traffic_pkg::light_t light_M1;
    traffic_pkg::light_t light_M2;
    traffic_pkg::light_t light_MT;
    traffic_pkg::light_t light_S;
    logic                fault_clr;
    traffic_pkg::light_t lamp_M1;
    traffic_pkg::light_t lamp_M2;
    traffic_pkg::light_t lamp_MT;
    traffic_pkg::light_t lamp_S;
    logic                fault;
    logic [2:0]          fault_code;

    modport master (
        output light_M1, light_M2, light_MT, light_S, fault_clr,
        input  lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
    );

    modport slave (
        input  light_M1, light_M2, light_MT, light_S, fault_clr,
        output lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
    );

endinterface

// File: rtl/traffic_blink_gen.sv
// Fail-safe blink phase: prescaled by BLINK_DIV while enabled, parked at phase-on otherwise.
module traffic_blink_gen #(
    parameter int unsigned BLINK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic phase_on_o
);

    localparam int unsigned DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;

    always_comb begin
        div_d   = '0;
        phase_d = 1'b1;
        if (en_i) begin
            phase_d = phase_q;
            if (div_q == DW'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign phase_on_o = phase_q;

endmodule

// File: rtl/traffic_lamp_safety_driver.sv
// Lamp driver with conflict/encoding monitor, latched flashing-red fail-safe and all-red recovery.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module traffic_lamp_safety_driver
    import traffic_pkg::*;
#(
    parameter int unsigned CONFLICT_CYC = 2,
    parameter int unsigned RECOVER_CYC  = 4,
    parameter int unsigned BLINK_DIV    = 1
`ifdef STALL_WDT_EN
    ,
    parameter int unsigned WDT_CYC      = 12
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_lamp_safety_driver_if.slave bus
);

    localparam int unsigned VW = $clog2(CONFLICT_CYC + 1);
    localparam int unsigned RW = $clog2(RECOVER_CYC + 1);
    localparam lamp_set_t   ALL_RED = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_RED};
    localparam lamp_set_t   ALL_OFF = '{m1: LT_OFF, m2: LT_OFF, mt: LT_OFF, s: LT_OFF};

    lamp_set_t     lights_q;
    logic [1:0]    state_q, state_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [2:0]    fc_q, fc_d;
    logic          invalid_c, conflict_c, viol_c, vhit_c, stall_hit_c;
    logic          phase_on;
    lamp_set_t     lamps_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lights_q <= ALL_RED;
        end else begin
            lights_q <= lamp_set_t'({bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S});
        end
    end

    // Monitor on the registered codes; the filter counter saturates at the threshold.
    always_comb begin
        invalid_c  = !is_onehot(lights_q.m1) || !is_onehot(lights_q.m2) ||
                     !is_onehot(lights_q.mt) || !is_onehot(lights_q.s);
        conflict_c = (is_active(lights_q.s) && (is_active(lights_q.m1) || is_active(lights_q.m2) ||
                                                is_active(lights_q.mt))) ||
                     (is_active(lights_q.mt) && is_active(lights_q.m2));
        viol_c     = invalid_c || conflict_c;
        vhit_c     = viol_c && (vcnt_q >= VW'(CONFLICT_CYC - 1));
        vcnt_d     = '0;
        if (viol_c) begin
            vcnt_d = (vcnt_q == VW'(CONFLICT_CYC)) ? vcnt_q : vcnt_q + VW'(1);
        end
    end

`ifdef STALL_WDT_EN
    localparam int unsigned WW = $clog2(WDT_CYC + 1);

    lamp_set_t     prev_q;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          chg_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= ALL_RED;
            wcnt_q <= '0;
        end else begin
            prev_q <= lights_q;
            wcnt_q <= wcnt_d;
        end
    end

    // Age of the registered code set, only tracked while running.
    always_comb begin
        chg_c       = (lights_q != prev_q);
        wcnt_d      = '0;
        stall_hit_c = 1'b0;
        if ((state_q == ST_RUN) && !chg_c) begin
            stall_hit_c = (wcnt_q >= WW'(WDT_CYC - 1));
            wcnt_d      = (wcnt_q == WW'(WDT_CYC)) ? wcnt_q : wcnt_q + WW'(1);
        end
    end
`else
    assign stall_hit_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RECOVER;
            vcnt_q  <= '0;
            rcnt_q  <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            rcnt_q  <= rcnt_d;
            fc_q    <= fc_d;
        end
    end

    // Fault code latches the causes present on the entry cycle and holds until cleared.
    always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        fc_d    = fc_q;
        case (state_q)
            ST_RUN: begin
                if (vhit_c || stall_hit_c) begin
                    state_d               = ST_FAULT;
                    fc_d[FC_INVALID]      = invalid_c;
                    fc_d[FC_CONFLICT]     = conflict_c;
                    fc_d[FC_STALL]        = stall_hit_c;
                end
            end
            ST_FAULT: begin
                if (!viol_c && bus.fault_clr) begin
                    state_d = ST_RECOVER;
                    fc_d    = '0;
                end
            end
            ST_RECOVER: begin
                if (vhit_c) begin
                    state_d               = ST_FAULT;
                    fc_d[FC_INVALID]      = invalid_c;
                    fc_d[FC_CONFLICT]     = conflict_c;
                    fc_d[FC_STALL]        = 1'b0;
                end else if (!viol_c) begin
                    if (rcnt_q >= RW'(RECOVER_CYC - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_RECOVER;
        endcase
    end

    traffic_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == ST_FAULT),
        .phase_on_o (phase_on)
    );

    always_comb begin
        lamps_c = ALL_RED;
        case (state_q)
            ST_RUN:   lamps_c = lights_q;
            ST_FAULT: lamps_c = phase_on ? ALL_RED : ALL_OFF;
            default:  lamps_c = ALL_RED;
        endcase
    end

    assign bus.lamp_M1    = lamps_c.m1;
    assign bus.lamp_M2    = lamps_c.m2;
    assign bus.lamp_MT    = lamps_c.mt;
    assign bus.lamp_S     = lamps_c.s;
    assign bus.fault      = (state_q == ST_FAULT);
    assign bus.fault_code = fc_q;

endmodule

// File: tb/tb_traffic_lamp_safety_driver.sv
// Bench for traffic_lamp_safety_driver: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the lamp/fault rules.
module tb_traffic_lamp_safety_driver;

    localparam int C_CYC = 2;
    localparam int R_CYC = 4;
    localparam int BLINK = 1;
    localparam int WDT   = 12;

    localparam logic [11:0] RED4  = 12'b100_100_100_100;
    localparam logic [11:0] LEGAL = 12'b001_001_100_100;
    localparam logic [11:0] YEL2  = 12'b010_010_100_100;
    localparam logic [11:0] CONF  = 12'b001_100_100_001;
    localparam logic [11:0] INV   = 12'b001_011_100_100;

    localparam int MD_RUN   = 0;
    localparam int MD_FAULT = 1;
    localparam int MD_REC   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    traffic_lamp_safety_driver_if bus ();

    traffic_lamp_safety_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state: mode, streak counters, fault age and latched code.
    int          m_mode, m_vs, m_rc, m_age, m_sa, m_next;
    logic [11:0] m_reg, m_prev;
    logic [2:0]  m_code;
    bit          m_inv, m_conf, m_viol, m_hit, m_stall, m_chg;

    function automatic bit lit_go(input logic [2:0] c);
        return (c[1] == 1'b1) || (c[0] == 1'b1);
    endfunction

    function automatic bit one_hot(input logic [2:0] c);
        return $countones(c) == 1;
    endfunction

    task automatic model_reset();
        m_mode = MD_REC; m_reg = RED4; m_prev = RED4;
        m_vs = 0; m_rc = 0; m_age = 0; m_sa = 0; m_code = 3'b000;
    endtask

    task automatic model_step(input logic [11:0] applied, input logic clr);
        m_inv  = !one_hot(m_reg[11:9]) || !one_hot(m_reg[8:6]) ||
                 !one_hot(m_reg[5:3])  || !one_hot(m_reg[2:0]);
        m_conf = (lit_go(m_reg[2:0]) && (lit_go(m_reg[11:9]) || lit_go(m_reg[8:6]) || lit_go(m_reg[5:3]))) ||
                 (lit_go(m_reg[5:3]) && lit_go(m_reg[8:6]));
        m_viol  = m_inv || m_conf;
        m_hit   = m_viol && (m_vs + 1 >= C_CYC);
        m_stall = 1'b0;
        m_chg   = (m_reg != m_prev);
`ifdef STALL_WDT_EN
        m_stall = (m_mode == MD_RUN) && !m_chg && (m_sa + 1 >= WDT);
        m_sa    = (m_mode == MD_RUN && !m_chg) ? ((m_sa + 1 < WDT) ? m_sa + 1 : WDT) : 0;
`endif
        m_next = m_mode;
        if (m_mode == MD_RUN) begin
            if (m_hit || m_stall) begin m_next = MD_FAULT; m_code = {m_stall, m_conf, m_inv}; end
        end else if (m_mode == MD_FAULT) begin
            if (!m_viol && clr) begin m_next = MD_REC; m_code = 3'b000; end
        end else begin
            if (m_hit) begin m_next = MD_FAULT; m_code = {1'b0, m_conf, m_inv}; end
            else if (m_viol) m_rc = 0;
            else if (m_rc + 1 >= R_CYC) m_next = MD_RUN;
            else m_rc = m_rc + 1;
        end
        if (m_next != MD_REC) m_rc = 0;
        m_age  = (m_mode == MD_FAULT && m_next == MD_FAULT) ? m_age + 1 : 0;
        m_vs   = m_viol ? ((m_vs + 1 < C_CYC) ? m_vs + 1 : C_CYC) : 0;
        m_mode = m_next;
        m_prev = m_reg;
        m_reg  = applied;
    endtask

    function automatic logic [15:0] exp_o();
        logic [11:0] l;
        if (m_mode == MD_RUN) l = m_reg;
        else if (m_mode == MD_FAULT && ((m_age / BLINK) % 2) != 0) l = 12'h000;
        else l = RED4;
        return {l, (m_mode == MD_FAULT), m_code};
    endfunction

    function automatic logic [15:0] dut_o();
        return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S, bus.fault, bus.fault_code};
    endfunction

    // One clock: drive at negedge, model steps at posedge, return at next negedge.
    task automatic tick(input logic [11:0] codes, input logic clr);
        {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} = codes;
        bus.fault_clr = clr;
        @(posedge clk);
        model_step(codes, clr);
        @(negedge clk);
        bus.fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} = LEGAL;
        bus.fault_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dut_o() !== {RED4, 4'b0000})
            $display("FAIL reset_state: got %h expected %h", dut_o(), {RED4, 4'b0000});
        if (dut_o() !== {RED4, 4'b0000}) errors++;
        rst_n = 1'b1;
    endtask

    task automatic test_legal_cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_o() !== {RED4, 4'b0000}) begin
                errors++; $display("FAIL recover_all_red[%0d]: got %h expected %h", i, dut_o(), {RED4, 4'b0000});
            end
            tick(LEGAL, 1'b0);
        end
        checks++;
        if (dut_o() !== {LEGAL, 4'b0000}) begin
            errors++; $display("FAIL run_follow: got %h expected %h", dut_o(), {LEGAL, 4'b0000});
        end
        tick(YEL2, 1'b0);
        checks++;
        if (dut_o() !== {YEL2, 4'b0000} || dut_o() !== exp_o()) begin
            errors++; $display("FAIL one_cycle_lag: got %h expected %h", dut_o(), {YEL2, 4'b0000});
        end
        tick(LEGAL, 1'b0);
    endtask

    task automatic test_conflict_fault();
        for (int i = 0; i < 2; i++) begin
            tick(CONF, 1'b0);
            checks++;
            if (dut_o() !== {CONF, 4'b0000}) begin
                errors++; $display("FAIL conflict_passthrough[%0d]: got %h expected %h", i, dut_o(), {CONF, 4'b0000});
            end
        end
        tick(CONF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_o() !== {((i % 2) == 0) ? RED4 : 12'h000, 1'b1, 3'b010} || dut_o() !== exp_o()) begin
                errors++; $display("FAIL conflict_blink[%0d]: got %h model %h", i, dut_o(), exp_o());
            end
            tick(CONF, 1'b0);
        end
    endtask

    task automatic test_clear_recover();
        tick(LEGAL, 1'b0);
        tick(LEGAL, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_o() !== {RED4, 4'b0000}) begin
                errors++; $display("FAIL clear_all_red[%0d]: got %h expected %h", i, dut_o(), {RED4, 4'b0000});
            end
            tick(LEGAL, 1'b0);
        end
        checks++;
        if (dut_o() !== {LEGAL, 4'b0000}) begin
            errors++; $display("FAIL clear_to_run: got %h expected %h", dut_o(), {LEGAL, 4'b0000});
        end
    endtask

    task automatic test_glitch();
        tick(CONF, 1'b0);
        checks++;
        if (dut_o() !== {CONF, 4'b0000}) begin
            errors++; $display("FAIL glitch_pass: got %h expected %h", dut_o(), {CONF, 4'b0000});
        end
        repeat (2) tick(LEGAL, 1'b0);
        checks++;
        if (dut_o() !== {LEGAL, 4'b0000} || dut_o() !== exp_o()) begin
            errors++; $display("FAIL glitch_no_fault: got %h expected %h", dut_o(), {LEGAL, 4'b0000});
        end
    endtask

    task automatic test_invalid();
        repeat (3) tick(INV, 1'b0);
        checks++;
        if (dut_o() !== {RED4, 1'b1, 3'b001}) begin
            errors++; $display("FAIL invalid_fault: got %h expected %h", dut_o(), {RED4, 1'b1, 3'b001});
        end
        for (int i = 0; i < 2; i++) begin
            tick(INV, 1'b1);
            checks++;
            if (bus.fault !== 1'b1 || bus.fault_code !== 3'b001 || dut_o() !== exp_o()) begin
                errors++; $display("FAIL clr_while_invalid[%0d]: got %h model %h", i, dut_o(), exp_o());
            end
        end
        test_clear_recover();
    endtask

    task automatic test_recover_refault();
        repeat (3) tick(CONF, 1'b0);
        tick(LEGAL, 1'b0);
        tick(LEGAL, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_o() !== {RED4, 4'b0000}) begin
                errors++; $display("FAIL recover_before_refault[%0d]: got %h expected %h", i, dut_o(), {RED4, 4'b0000});
            end
            tick((i == 2) ? LEGAL : CONF, 1'b0);
        end
        checks++;
        if (dut_o() !== {RED4, 1'b1, 3'b010} || dut_o() !== exp_o()) begin
            errors++; $display("FAIL recover_refault: got %h expected %h", dut_o(), {RED4, 1'b1, 3'b010});
        end
        tick(LEGAL, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_o() !== {RED4, 4'b0000}) begin
            errors++; $display("FAIL async_reset_in_fault: got %h expected %h", dut_o(), {RED4, 4'b0000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(LEGAL, 1'b0);
            checks++;
            if (dut_o() !== exp_o()) begin
                errors++; $display("FAIL post_reset_model[%0d]: got %h model %h", i, dut_o(), exp_o());
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 20; i++) begin
            tick(LEGAL, 1'b0);
            checks++;
            if (dut_o() !== exp_o()) begin
                errors++; $display("FAIL stall_model[%0d]: got %h model %h", i, dut_o(), exp_o());
            end
        end
        checks++;
`ifdef STALL_WDT_EN
        if (bus.fault !== 1'b1 || bus.fault_code !== 3'b100) begin
            errors++; $display("FAIL stall_fault: got fault=%b code=%b expected 1/100", bus.fault, bus.fault_code);
        end
`else
        if (dut_o() !== {LEGAL, 4'b0000}) begin
            errors++; $display("FAIL stall_disabled: got %h expected %h", dut_o(), {LEGAL, 4'b0000});
        end
`endif
    endtask

    function automatic logic [11:0] rand_codes();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return LEGAL;
            1: return 12'b001_100_001_100;
            2: return 12'b100_100_100_001;
            3: return RED4;
            4: return YEL2;
            5: return 12'b100_100_100_010;
            6: return 12'($urandom);
            default: return {3'(1 << $urandom_range(0, 2)), 3'(1 << $urandom_range(0, 2)),
                             3'(1 << $urandom_range(0, 2)), 3'(1 << $urandom_range(0, 2))};
        endcase
    endfunction

    task automatic test_random();
        logic [11:0] codes;
        int          hold;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 150; n++) begin
            codes = rand_codes();
            hold  = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                tick(codes, ($urandom_range(0, 3) == 0));
                checks++;
                if (dut_o() !== exp_o()) begin
                    errors++; $display("FAIL random[%0d.%0d]: in %h got %h model %h", n, h, codes, dut_o(), exp_o());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict_fault();
        test_clear_recover();
        test_glitch();
        test_invalid();
        test_glitch();
        test_recover_refault();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
